serial_addsub: RTL

Bit-serial add/subtract unit that computes one bit per clock, LSB first. It reuses one full_adder cell and one full_sub cell plus a carry/borrow flip-flop. It is the sequential, multi-bit counterpart to the combinational adder/subtractor cells and sits in the ALU datapath as an area-cheap arithmetic path with a start/done handshake.

---
 rtl/serial_addsub.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, one bit per clock with start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // {carry, sum}
    function automatic logic [1:0] full_adder(input logic x, input logic y, input logic ci);
        return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
    endfunction

    // {borrow, difference}
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        return {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic [1:0]       bit_r;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state, bit-slice datapath and result load on the final bit
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        c_d      = c_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        bit_r    = op_q ? full_sub(a_sh_q[0], b_sh_q[0], c_q)
                        : full_adder(a_sh_q[0], b_sh_q[0], c_q);
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = op;
                    c_d     = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                acc_d  = {bit_r[0], acc_q[WIDTH-1:1]};
                c_d    = bit_r[1];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = acc_d;
                    cout_d   = bit_r[1];
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d    = c_q ^ bit_r[1];
`endif
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            c_q      <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            c_q      <= c_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign cout   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule
